// File: rtl/sparc_exu_div_seq_if.sv
// ============================================================================
// Module      : sparc_exu_div_seq_if
// Description : Handshake and strobe bundle between ECL/datapath and the
//               EXU divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sparc_exu_div_seq_if;
    // ECL request side and datapath status flags
    logic ecl_div_req_e;
    logic ecl_div_div64_e;
    logic ecl_div_signed_e;
    logic ecl_div_kill;
    logic ecl_div_ack_g;
    logic div_ecl_dividend_msb;
    logic div_ecl_xin_msb_l;
    logic div_ecl_d_msb;
    logic div_ecl_x_msb;
    logic div_ecl_zero_rs2_e;
    logic div_ecl_upper33_zero;
    logic div_ecl_upper33_one;

    // Sequencer strobes and status
    logic div_ecl_rdy;
    logic ecl_div_ld_inputs;
    logic ecl_div_keepx;
    logic ecl_div_sel_adder;
    logic ecl_div_keep_d;
    logic ecl_div_almostlast_cycle;
    logic ecl_div_last_cycle;
    logic ecl_div_subtract_l;
    logic ecl_div_cin;
    logic ecl_div_newq;
    logic ecl_div_dividend_sign;
    logic ecl_div_xinmask;
    logic ecl_div_sel_64b;
    logic ecl_div_sel_u32;
    logic ecl_div_sel_pos32;
    logic ecl_div_sel_neg32;
    logic div_ecl_done_g;
    logic div_ecl_dzero_g;

    // Requester / datapath side
    modport master (
        output ecl_div_req_e, ecl_div_div64_e, ecl_div_signed_e, ecl_div_kill,
               ecl_div_ack_g, div_ecl_dividend_msb, div_ecl_xin_msb_l,
               div_ecl_d_msb, div_ecl_x_msb, div_ecl_zero_rs2_e,
               div_ecl_upper33_zero, div_ecl_upper33_one,
        input  div_ecl_rdy, ecl_div_ld_inputs, ecl_div_keepx, ecl_div_sel_adder,
               ecl_div_keep_d, ecl_div_almostlast_cycle, ecl_div_last_cycle,
               ecl_div_subtract_l, ecl_div_cin, ecl_div_newq,
               ecl_div_dividend_sign, ecl_div_xinmask, ecl_div_sel_64b,
               ecl_div_sel_u32, ecl_div_sel_pos32, ecl_div_sel_neg32,
               div_ecl_done_g, div_ecl_dzero_g
    );

    // Sequencer side
    modport slave (
        input  ecl_div_req_e, ecl_div_div64_e, ecl_div_signed_e, ecl_div_kill,
               ecl_div_ack_g, div_ecl_dividend_msb, div_ecl_xin_msb_l,
               div_ecl_d_msb, div_ecl_x_msb, div_ecl_zero_rs2_e,
               div_ecl_upper33_zero, div_ecl_upper33_one,
        output div_ecl_rdy, ecl_div_ld_inputs, ecl_div_keepx, ecl_div_sel_adder,
               ecl_div_keep_d, ecl_div_almostlast_cycle, ecl_div_last_cycle,
               ecl_div_subtract_l, ecl_div_cin, ecl_div_newq,
               ecl_div_dividend_sign, ecl_div_xinmask, ecl_div_sel_64b,
               ecl_div_sel_u32, ecl_div_sel_pos32, ecl_div_sel_neg32,
               div_ecl_done_g, div_ecl_dzero_g
    );
endinterface

`default_nettype wire

// File: rtl/sparc_exu_div_seq.sv
// ============================================================================
// Module      : sparc_exu_div_seq
// Description : Sequencer for the EXU non-restoring divide datapath. Accepts
//               one divide at a time, issues per-cycle datapath strobes,
//               reports completion or divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparc_exu_div_seq #(
    parameter int ITER = 64,
    parameter int CNTW = 7
) (
    input  wire               rclk,
    input  wire               arst_l,
    sparc_exu_div_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_WB   = 3'd4,
        ST_DONE = 3'd5,
        ST_DZ   = 3'd6
    } state_t;

    // Counter value on the penultimate iteration and the saturated exit value
    localparam logic [CNTW-1:0] c_cnt_last = CNTW'(ITER - 1);
    localparam logic [CNTW-1:0] c_cnt_iter = CNTW'(ITER);
    localparam logic [CNTW-1:0] c_cnt_one  = CNTW'(1);

    state_t          r_state;
    state_t          w_next_state;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_next;

    // Per-divide attributes latched at accept, range flags latched at FIX
    logic r_div64;
    logic r_signed;
    logic r_dividend_sign;
    logic r_x_neg;
    logic r_upper33_zero;
    logic r_upper33_one;

    logic w_rdy;
    logic w_ld_inputs;
    logic w_keepx;
    logic w_sel_adder;
    logic w_keep_d;
    logic w_almostlast;
    logic w_last;
    logic w_subtract_l;
    logic w_newq;
    logic w_xinmask;
    logic w_done;
    logic w_dzero;
    logic w_load_flags;
    logic w_fix_capture;
    logic w_sign_diff;
    logic w_q_nonneg;

    // State and iteration counter registers
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Latch divide attributes on accept and quotient range flags at fixup
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_div64         <= 1'b1;
            r_signed        <= 1'b0;
            r_dividend_sign <= 1'b0;
            r_x_neg         <= 1'b0;
            r_upper33_zero  <= 1'b0;
            r_upper33_one   <= 1'b0;
        end else begin
            if (w_load_flags) begin
                r_div64         <= bus.ecl_div_div64_e;
                r_signed        <= bus.ecl_div_signed_e;
                r_dividend_sign <= bus.ecl_div_signed_e & bus.div_ecl_dividend_msb;
                r_x_neg         <= bus.ecl_div_signed_e & ~bus.div_ecl_xin_msb_l;
            end
            if (w_fix_capture) begin
                r_upper33_zero <= bus.div_ecl_upper33_zero;
                r_upper33_one  <= bus.div_ecl_upper33_one;
            end
        end
    end

    // Next-state, counter and per-cycle strobe decode; kill overrides everything
    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = r_cnt;
        w_rdy         = 1'b0;
        w_ld_inputs   = 1'b0;
        w_keepx       = 1'b1;
        w_sel_adder   = 1'b0;
        w_keep_d      = 1'b0;
        w_almostlast  = 1'b0;
        w_last        = 1'b0;
        w_subtract_l  = 1'b1;
        w_newq        = 1'b0;
        w_xinmask     = 1'b0;
        w_done        = 1'b0;
        w_dzero       = 1'b0;
        w_load_flags  = 1'b0;
        w_fix_capture = 1'b0;
        // Signs differ -> add divisor back; signs agree -> subtract
        w_sign_diff   = bus.div_ecl_d_msb ^ bus.div_ecl_x_msb;

        case (r_state)
            ST_IDLE: begin
                w_rdy      = 1'b1;
                w_cnt_next = '0;
                if (bus.ecl_div_req_e) begin
                    if (bus.div_ecl_zero_rs2_e) begin
                        w_next_state = ST_DZ;
                    end else begin
                        w_ld_inputs  = 1'b1;
                        w_keepx      = 1'b0;
                        w_xinmask    = bus.ecl_div_signed_e & ~bus.div_ecl_xin_msb_l;
                        w_load_flags = 1'b1;
                        w_next_state = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                w_sel_adder  = 1'b1;
                w_subtract_l = w_sign_diff;
                w_cnt_next   = c_cnt_one;
                w_next_state = ST_ITER;
            end
            ST_ITER: begin
                w_sel_adder  = 1'b1;
                w_subtract_l = w_sign_diff;
                w_newq       = ~w_sign_diff;
                if (r_cnt == c_cnt_last) begin
                    // X is cleared on this cycle so the fixup adds zero
                    w_almostlast = 1'b1;
                    w_cnt_next   = c_cnt_iter;
                    w_next_state = ST_FIX;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            ST_FIX: begin
                w_last        = 1'b1;
                w_sel_adder   = 1'b1;
                w_keepx       = 1'b0;
                w_fix_capture = 1'b1;
                w_next_state  = ST_WB;
            end
            ST_WB: begin
                w_keep_d     = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (bus.ecl_div_ack_g) begin
                    w_next_state = ST_IDLE;
                    w_cnt_next   = '0;
                end
            end
            ST_DZ: begin
                w_dzero = 1'b1;
                if (bus.ecl_div_ack_g) begin
                    w_next_state = ST_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        if (bus.ecl_div_kill) begin
            w_next_state  = ST_IDLE;
            w_cnt_next    = '0;
            w_ld_inputs   = 1'b0;
            w_keepx       = 1'b1;
            w_sel_adder   = 1'b0;
            w_keep_d      = 1'b0;
            w_almostlast  = 1'b0;
            w_last        = 1'b0;
            w_subtract_l  = 1'b1;
            w_newq        = 1'b0;
            w_xinmask     = 1'b0;
            w_done        = 1'b0;
            w_dzero       = 1'b0;
            w_load_flags  = 1'b0;
            w_fix_capture = 1'b0;
        end
    end

    // Quotient sign: in-range results follow the upper-33 flags, overflowed
    // results take the sign implied by the operand signs
    assign w_q_nonneg = r_upper33_zero |
                        (~r_upper33_one & ~(r_dividend_sign ^ r_x_neg));

    assign bus.div_ecl_rdy              = w_rdy;
    assign bus.ecl_div_ld_inputs        = w_ld_inputs;
    assign bus.ecl_div_keepx            = w_keepx;
    assign bus.ecl_div_sel_adder        = w_sel_adder;
    assign bus.ecl_div_keep_d           = w_keep_d;
    assign bus.ecl_div_almostlast_cycle = w_almostlast;
    assign bus.ecl_div_last_cycle       = w_last;
    assign bus.ecl_div_subtract_l       = w_subtract_l;
    assign bus.ecl_div_cin              = ~w_subtract_l;
    assign bus.ecl_div_newq             = w_newq;
    assign bus.ecl_div_dividend_sign    = r_dividend_sign;
    assign bus.ecl_div_xinmask          = w_xinmask;
    assign bus.div_ecl_done_g           = w_done;
    assign bus.div_ecl_dzero_g          = w_dzero;

    // Result select is decoded from latched flags so it is one-hot every cycle
    assign bus.ecl_div_sel_64b   = r_div64;
    assign bus.ecl_div_sel_u32   = ~r_div64 & ~r_signed;
    assign bus.ecl_div_sel_pos32 = ~r_div64 &  r_signed &  w_q_nonneg;
    assign bus.ecl_div_sel_neg32 = ~r_div64 &  r_signed & ~w_q_nonneg;

endmodule

`default_nettype wire

// File: tb/tb_sparc_exu_div_seq.sv
// ============================================================================
// Module      : tb_sparc_exu_div_seq
// Description : Self-checking bench for the EXU divide sequencer. A
//               transaction-timeline model predicts every strobe each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sparc_exu_div_seq;
    localparam int ITER = 64;

    logic rclk   = 1'b0;
    logic arst_l = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;
    logic [31:0] cyc = '0;

    sparc_exu_div_seq_if bus ();

    sparc_exu_div_seq #(.ITER(ITER), .CNTW(7)) dut (
        .rclk   (rclk),
        .arst_l (arst_l),
        .bus    (bus)
    );

    always #5 rclk = ~rclk;

    // Timeline model: mode 0 idle, 1 divide (k = cycles since accept), 2 div-by-zero
    int   m_mode;
    int   m_k;
    logic m_div64, m_signed, m_dsign, m_xneg, m_uz, m_uo;

    always @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            m_mode <= 0; m_k <= 0; m_div64 <= 1'b1; m_signed <= 1'b0;
            m_dsign <= 1'b0; m_xneg <= 1'b0; m_uz <= 1'b0; m_uo <= 1'b0;
        end else if (bus.ecl_div_kill) begin
            m_mode <= 0; m_k <= 0;
        end else begin
            case (m_mode)
                0: if (bus.ecl_div_req_e) begin
                    if (bus.div_ecl_zero_rs2_e) m_mode <= 2;
                    else begin
                        m_mode   <= 1;
                        m_k      <= 1;
                        m_div64  <= bus.ecl_div_div64_e;
                        m_signed <= bus.ecl_div_signed_e;
                        m_dsign  <= bus.ecl_div_signed_e & bus.div_ecl_dividend_msb;
                        m_xneg   <= bus.ecl_div_signed_e & ~bus.div_ecl_xin_msb_l;
                    end
                end
                1: begin
                    if (m_k == ITER + 1) begin
                        m_uz <= bus.div_ecl_upper33_zero;
                        m_uo <= bus.div_ecl_upper33_one;
                    end
                    if (m_k >= ITER + 3) begin
                        if (bus.ecl_div_ack_g) begin m_mode <= 0; m_k <= 0; end
                    end else m_k <= m_k + 1;
                end
                default: if (bus.ecl_div_ack_g) m_mode <= 0;
            endcase
        end
    end

    // Expected outputs derived from the timeline and compared each cycle
    logic e_rdy, e_ld, e_keepx, e_seladd, e_keepd, e_alm, e_last, e_subl, e_newq, e_xmask, e_done, e_dz;
    logic e_dx, e_qpos;
    logic [13:0] e_vec, a_vec;
    logic [3:0]  e_sel, a_sel;

    always @(negedge rclk) begin
        if (chk_en) begin
            e_rdy = (m_mode == 0); e_ld = 1'b0; e_keepx = 1'b1; e_seladd = 1'b0;
            e_keepd = 1'b0; e_alm = 1'b0; e_last = 1'b0; e_subl = 1'b1; e_newq = 1'b0;
            e_xmask = 1'b0; e_done = 1'b0; e_dz = 1'b0;
            e_dx = bus.div_ecl_d_msb ^ bus.div_ecl_x_msb;
            if (!bus.ecl_div_kill) begin
                if (m_mode == 0 && bus.ecl_div_req_e && !bus.div_ecl_zero_rs2_e) begin
                    e_ld = 1'b1; e_keepx = 1'b0;
                    e_xmask = bus.ecl_div_signed_e & ~bus.div_ecl_xin_msb_l;
                end
                if (m_mode == 1) begin
                    if (m_k >= 1 && m_k <= ITER) begin
                        e_seladd = 1'b1; e_subl = e_dx;
                        if (m_k >= 2) e_newq = ~e_dx;
                    end
                    e_alm = (m_k == ITER);
                    if (m_k == ITER + 1) begin e_last = 1'b1; e_seladd = 1'b1; e_keepx = 1'b0; end
                    e_keepd = (m_k == ITER + 2);
                    e_done  = (m_k >= ITER + 3);
                end
                e_dz = (m_mode == 2);
            end
            e_vec = {e_rdy, e_ld, e_keepx, e_seladd, e_keepd, e_alm, e_last, e_subl,
                     ~e_subl, e_newq, m_dsign, e_xmask, e_done, e_dz};
            a_vec = {bus.div_ecl_rdy, bus.ecl_div_ld_inputs, bus.ecl_div_keepx,
                     bus.ecl_div_sel_adder, bus.ecl_div_keep_d, bus.ecl_div_almostlast_cycle,
                     bus.ecl_div_last_cycle, bus.ecl_div_subtract_l, bus.ecl_div_cin,
                     bus.ecl_div_newq, bus.ecl_div_dividend_sign, bus.ecl_div_xinmask,
                     bus.div_ecl_done_g, bus.div_ecl_dzero_g};
            checks++;
            if (a_vec !== e_vec) begin
                failures++;
                $display("FAIL strobes t=%0t actual=%b expected=%b", $time, a_vec, e_vec);
            end
            a_sel = {bus.ecl_div_sel_64b, bus.ecl_div_sel_u32, bus.ecl_div_sel_pos32, bus.ecl_div_sel_neg32};
            checks++;
            if (!$onehot(a_sel)) begin
                failures++;
                $display("FAIL sel_onehot t=%0t actual=%b expected=one-hot", $time, a_sel);
            end
            if (m_mode == 1 && m_k >= ITER + 2) begin
                e_qpos = m_uz | (~m_uo & (m_dsign == m_xneg));
                if (m_div64)        e_sel = 4'b1000;
                else if (!m_signed) e_sel = 4'b0100;
                else if (e_qpos)    e_sel = 4'b0010;
                else                e_sel = 4'b0001;
                checks++;
                if (a_sel !== e_sel) begin
                    failures++;
                    $display("FAIL sel_result t=%0t actual=%b expected=%b", $time, a_sel, e_sel);
                end
            end
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
        cyc++;
        bus.div_ecl_d_msb = cyc[0] ^ cyc[2];
        bus.div_ecl_x_msb = cyc[1];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic start(input logic d64, input logic sgn, input logic dmsb,
                         input logic xin_l, input logic uz, input logic uo);
        bus.ecl_div_div64_e      = d64;
        bus.ecl_div_signed_e     = sgn;
        bus.div_ecl_dividend_msb = dmsb;
        bus.div_ecl_xin_msb_l    = xin_l;
        bus.div_ecl_upper33_zero = uz;
        bus.div_ecl_upper33_one  = uo;
        bus.ecl_div_req_e        = 1'b1;
        tick();
        bus.ecl_div_req_e        = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.div_ecl_done_g && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack();
        bus.ecl_div_ack_g = 1'b1;
        tick();
        bus.ecl_div_ack_g = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.ecl_div_req_e = 1'b0; bus.ecl_div_div64_e = 1'b0; bus.ecl_div_signed_e = 1'b0;
        bus.ecl_div_kill = 1'b0; bus.ecl_div_ack_g = 1'b0; bus.div_ecl_dividend_msb = 1'b0;
        bus.div_ecl_xin_msb_l = 1'b1; bus.div_ecl_d_msb = 1'b0; bus.div_ecl_x_msb = 1'b0;
        bus.div_ecl_zero_rs2_e = 1'b0; bus.div_ecl_upper33_zero = 1'b0; bus.div_ecl_upper33_one = 1'b0;

        // Reset values
        repeat (2) tick();
        check("reset_rdy", 32'(bus.div_ecl_rdy), 32'd1);
        check("reset_keepx_subl_sel64", {29'd0, bus.ecl_div_keepx, bus.ecl_div_subtract_l, bus.ecl_div_sel_64b}, 32'd7);
        check("reset_done_dz", {30'd0, bus.div_ecl_done_g, bus.div_ecl_dzero_g}, 32'd0);
        arst_l = 1'b1;
        chk_en = 1'b1;
        tick();

        // 64b unsigned 100/7: quotient 14 fits, upper33 all zero
        start(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_done(lat);
        check("u64_latency", 32'(lat), 32'd67);
        check("u64_sel64", 32'(bus.ecl_div_sel_64b), 32'd1);
        check("u64_dzero", 32'(bus.div_ecl_dzero_g), 32'd0);
        repeat (2) tick();
        check("u64_done_held", 32'(bus.div_ecl_done_g), 32'd1);
        ack();
        check("u64_done_drop", {30'd0, bus.div_ecl_done_g, bus.div_ecl_rdy}, 32'd1);

        // 32b signed -7/2 = -3: upper33 all ones, negative result path
        start(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("s32_dividend_sign", 32'(bus.ecl_div_dividend_sign), 32'd1);
        wait_done(lat);
        check("s32_latency", 32'(lat), 32'd67);
        check("s32_sel_neg32", 32'(bus.ecl_div_sel_neg32), 32'd1);
        ack();

        // 32b unsigned 0x1_00000000/1: quotient overflows 32 bits
        start(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done(lat);
        check("u32_sel_u32", 32'(bus.ecl_div_sel_u32), 32'd1);
        ack();

        // Signed positive overflow: positive operands, upper33 mixed
        start(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done(lat);
        check("s32_sel_pos32", 32'(bus.ecl_div_sel_pos32), 32'd1);
        ack();

        // Divide by zero: no load, trap next cycle, held until ack
        bus.div_ecl_zero_rs2_e = 1'b1;
        bus.ecl_div_req_e = 1'b1;
        #1;
        check("dz_no_ld", 32'(bus.ecl_div_ld_inputs), 32'd0);
        tick();
        bus.ecl_div_req_e = 1'b0;
        bus.div_ecl_zero_rs2_e = 1'b0;
        check("dz_trap", {30'd0, bus.div_ecl_dzero_g, bus.div_ecl_rdy}, 32'd2);
        repeat (3) tick();
        check("dz_held", 32'(bus.div_ecl_dzero_g), 32'd1);
        ack();
        check("dz_release", {30'd0, bus.div_ecl_dzero_g, bus.div_ecl_rdy}, 32'd1);

        // Ack while idle is ignored
        ack();
        check("idle_ack_rdy", 32'(bus.div_ecl_rdy), 32'd1);

        // Kill beats a simultaneous request
        bus.ecl_div_req_e = 1'b1;
        bus.ecl_div_kill  = 1'b1;
        #1;
        check("kill_req_no_ld", 32'(bus.ecl_div_ld_inputs), 32'd0);
        tick();
        bus.ecl_div_req_e = 1'b0;
        bus.ecl_div_kill  = 1'b0;
        check("kill_req_idle", 32'(bus.div_ecl_rdy), 32'd1);

        // Kill at iteration 30, then a fresh divide completes normally
        start(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (30) tick();
        bus.ecl_div_kill = 1'b1;
        #1;
        check("kill_strobes_off", 32'(bus.ecl_div_sel_adder), 32'd0);
        tick();
        bus.ecl_div_kill = 1'b0;
        check("kill_rdy_next", 32'(bus.div_ecl_rdy), 32'd1);
        repeat (70) tick();
        check("kill_no_done", 32'(bus.div_ecl_done_g), 32'd0);
        start(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_done(lat);
        check("after_kill_latency", 32'(lat), 32'd67);
        ack();

        // Busy request ignored, then asynchronous reset mid-divide
        start(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        bus.ecl_div_req_e = 1'b1;
        tick();
        bus.ecl_div_req_e = 1'b0;
        repeat (4) tick();
        #1;
        arst_l = 1'b0;
        #1;
        check("arst_rdy_sel64", {30'd0, bus.div_ecl_rdy, bus.ecl_div_sel_64b}, 32'd3);
        check("arst_strobes", {29'd0, bus.ecl_div_sel_adder, bus.ecl_div_newq, bus.ecl_div_cin}, 32'd0);
        #1;
        arst_l = 1'b1;
        repeat (80) tick();
        check("arst_no_done", {30'd0, bus.div_ecl_done_g, bus.div_ecl_rdy}, 32'd1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
